// File: rtl/serdes_pkg.sv
// Shared constants and state encoding for the 8b serial link: COMMA idle/sync
// character, preamble length and counter widths used by the transmitter and receiver.
package serdes_pkg;

   localparam logic [7:0] COMMA     = 8'hBC;
   localparam int         N_SYNC    = 4;
   localparam int         SYNC_W    = 3;
   localparam int         BIT_CNT_W = 3;

   typedef enum logic {
      PREAMBLE = 1'b0,
      RUN      = 1'b1
   } tx_state_t;

endpackage

// File: rtl/shift_reg_piso.sv
// 8-bit parallel-in serial-out shift register, MSB first; load wins over shift.
// Serial output is the combinational MSB of the register, so the caller decides the output timing.
module shift_reg_piso #(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       load,
   input  logic       shift_en,
   input  logic [7:0] par_in,
   output logic       ser_out
);

   logic [7:0] q;

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= par_in;
      end else if (shift_en) begin
         q <= {q[6:0], 1'b0};
      end
   end

   assign ser_out = q[7];

endmodule

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: COMMA preamble after reset, then hold-register bytes or COMMA fill,
// one bit per clk_8f with registered outputs; ready_out drops while the single hold entry is full.
import serdes_pkg::*;

module paralelo_serial_tx (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       frame_start,
   output logic       valid_tx,
   output logic       sync_done
);

   tx_state_t            state;
   tx_state_t            state_nxt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [SYNC_W-1:0]    pre_cnt;
   logic                 hold_full;
   logic [7:0]           hold_dat;
   logic                 cur_data;

   logic                 frame_end;
   logic                 last_pre;
   logic                 data_ok;
   logic                 take_hold;
   logic [7:0]           next_frame;
   logic                 xfer;
   logic                 ser_bit;

   assign frame_end = (bit_cnt == '1);
   assign last_pre  = (pre_cnt == SYNC_W'(N_SYNC - 1));
   assign ready_out = ~hold_full;
   assign xfer      = valid_in & ready_out;

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state <= PREAMBLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == PREAMBLE && frame_end && last_pre) begin
         state_nxt = RUN;
      end
   end

   // The frame after the last preamble COMMA may already carry data.
   always_comb begin
      data_ok    = (state == RUN) || last_pre;
      take_hold  = frame_end && data_ok && hold_full;
      next_frame = take_hold ? hold_dat : COMMA;
   end

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (state == PREAMBLE && frame_end) begin
         pre_cnt <= pre_cnt + SYNC_W'(1);
      end
   end

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         bit_cnt     <= '0;
         hold_full   <= 1'b0;
         hold_dat    <= 8'h00;
         cur_data    <= 1'b0;
         data_out    <= 1'b0;
         frame_start <= 1'b0;
         valid_tx    <= 1'b0;
         sync_done   <= 1'b0;
      end else begin
         bit_cnt     <= bit_cnt + BIT_CNT_W'(1);
         data_out    <= ser_bit;
         frame_start <= (bit_cnt == '0);
         valid_tx    <= cur_data;
         sync_done   <= (state == RUN);
         if (frame_end) begin
            cur_data <= take_hold;
         end
         if (xfer) begin
            hold_full <= 1'b1;
            hold_dat  <= data_in;
         end else if (take_hold) begin
            hold_full <= 1'b0;
         end
      end
   end

   shift_reg_piso #(
      .RESET_VAL (COMMA)
   ) u_shift (
      .clk_8f   (clk_8f),
      .reset    (reset),
      .load     (frame_end),
      .shift_en (1'b1),
      .par_in   (next_frame),
      .ser_out  (ser_bit)
   );

endmodule
